// File: rtl/fast_kp_store.sv
// fast_kp_store: per-pyramid-level FAST keypoint collector.
// Walks the raster-ordered corner-flag stream and keeps the current pixel
// coordinates. Each corner that lies outside the EDGE border is written to the
// keypoint RAM as raw {col,row}. At frame end it publishes the keypoint count
// and pulses done for one cycle.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   frame_start  one-cycle pulse before the first pixel of a frame
//   pix_valid    detector output valid this cycle
//   corner       FAST corner flag (qualified by pix_valid)
//   XY_out       {col[9:0],row[9:0]} write data (raw counter coordinates)
//   addr_kp      keypoint RAM write address
//   wren_kp      keypoint RAM write enable (one cycle per keypoint)
//   num_kp       keypoint count of the last completed frame
//   done         one-cycle pulse when num_kp is valid
//   overflow     sticky per frame: a keypoint was dropped for capacity
module fast_kp_store #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int EDGE   = 38,
    parameter int MAX_KP = 16383
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic        corner,
    output logic [19:0] XY_out,
    output logic [13:0] addr_kp,
    output logic        wren_kp,
    output logic [13:0] num_kp,
    output logic        done,
    output logic        overflow
);

    localparam logic [9:0]  COL_LAST = 10'(IMG_W - 1);
    localparam logic [9:0]  ROW_LAST = 10'(IMG_H - 1);
    localparam logic [9:0]  EDGE_C   = 10'(EDGE);
    localparam logic [13:0] KP_CAP   = 14'(MAX_KP);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [9:0]  col;
    logic [9:0]  row;
    logic [13:0] count;
    logic        accept;

    // Corners inside the border band are discarded: the detector window is not
    // yet filled there.
    assign accept = pix_valid & corner & (col >= EDGE_C) & (row >= EDGE_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            col      <= '0;
            row      <= '0;
            count    <= '0;
            XY_out   <= '0;
            addr_kp  <= '0;
            wren_kp  <= 1'b0;
            num_kp   <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wren_kp <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state    <= RUN;
                        col      <= '0;
                        row      <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                    end
                end
                RUN: begin
                    // A restart wins over a pixel in the same cycle; any write
                    // registered last cycle is already on the RAM port.
                    if (frame_start) begin
                        col      <= '0;
                        row      <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                    end else if (pix_valid) begin
                        if (accept) begin
                            if (count < KP_CAP) begin
                                XY_out  <= {col, row};
                                addr_kp <= count;
                                wren_kp <= 1'b1;
                                count   <= count + 14'd1;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end
                        if (col == COL_LAST) begin
                            col <= '0;
                            if (row == ROW_LAST) begin
                                row   <= '0;
                                state <= DONE;
                            end else begin
                                row <= row + 10'd1;
                            end
                        end else begin
                            col <= col + 10'd1;
                        end
                    end
                end
                DONE: begin
                    // count already includes the last pixel's keypoint, whose
                    // write is on the RAM port during this cycle.
                    num_kp <= count;
                    done   <= 1'b1;
                    if (frame_start) begin
                        state    <= RUN;
                        col      <= '0;
                        row      <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
